// File: rtl/fetch_unit_pkg.sv
// Shared fetch/control definitions: FSM encoding, PC mux select, fetch payload and RV32I opcodes.
package fetch_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_KEEP = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    localparam logic [XLEN-1:0]  NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [OPC_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_S    = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_L    = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_B    = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR = 7'b1100111;

endpackage

// File: rtl/pc_reg.sv
// Program counter: holds, advances by 4 (wrapping) or loads a word-aligned redirect target.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_e         sel_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:  pc_d = pc_q + XLEN'(4);
            PC_LOAD: pc_d = redirect_pc_i & PC_ALIGN_MASK;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, registered instruction handed to decode,
// redirects flush anything in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [OPC_W-1:0] opcode,
    output logic [XLEN-1:0]  instr_pc
);

    fetch_state_e    state_q, state_d;
    fetch_pkt_t      pkt_q, pkt_d;
    logic            valid_q, valid_d;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_i        (pc_sel),
        .redirect_pc_i(redirect_pc),
        .pc_o         (pc)
    );

    // The request strobe is gated by redirect in the same cycle, so it is decoded from state.
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        valid_d   = valid_q;
        pc_sel    = PC_KEEP;
        imem_req  = 1'b0;
        imem_addr = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_addr = pc;
                if (redirect) begin
                    pc_sel = PC_LOAD;
                end else begin
                    imem_req = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_sel  = PC_LOAD;
                    state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
                end else if (imem_rvalid) begin
                    pkt_d   = '{instr: imem_rdata, pc: pc};
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_sel = PC_LOAD;
                end
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                // Redirect takes priority over a simultaneous accept for the next PC.
                if (redirect) begin
                    pc_sel  = PC_LOAD;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    pc_sel  = PC_INC;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            pkt_q   <= '{instr: NOP, pc: '0};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = pkt_q.instr;
    assign instr_pc    = pkt_q.pc;
    assign opcode      = pkt_q.instr[OPC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed scenarios plus random memory latency/backpressure/redirects
// checked against a stream-level model of the expected fetch PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic        w_resp_next = 1'b0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [6:0]  w_op;
    logic [31:0] w_pc;
    logic [31:0] w_log[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(32'h0000_0013),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .opcode(w_op), .instr_pc(w_pc)
    );

    // Single-cycle-latency memory for the wrap instance.
    always @(negedge clk) begin
        w_rvalid    = w_resp_next;
        w_resp_next = 1'b0;
        if (w_req === 1'b1) begin
            if (w_log.size() < 8) w_log.push_back(w_addr);
            w_resp_next = 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;

    logic        s_req, s_valid, s_rv;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [6:0]  s_op;
    logic [31:0] model_next;
    bit          outstanding;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat;
    logic [31:0] req_log[$];
    int          hs_cnt;
    int          n, hs0;
    bit          first_done, saw_flushed;
    bit          rdy_r, redir_r;
    logic [31:0] rpc_r;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00C5_8533;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end
        end
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        s_req = imem_req;   s_addr  = imem_addr;  s_rv = imem_rvalid;
        s_valid = instr_valid; s_instr = instr; s_pc = instr_pc; s_op = opcode;
        if (s_req) begin
            chk("single_outstanding", 32'(outstanding), 32'h0);
            chk("req_addr", s_addr, model_next);
        end
        if (s_valid) begin
            chk("valid_pc", s_pc, model_next);
            chk("valid_instr", s_instr, mem_word(s_pc));
            chk("valid_opcode", 32'(s_op), mem_word(s_pc) & 32'h7F);
        end
        @(posedge clk);
        if (s_rv) outstanding = 1'b0;
        if (s_req) begin
            outstanding = 1'b1;
            pend        = 1'b1;
            pend_cnt    = lat;
            pend_addr   = s_addr;
            req_log.push_back(s_addr);
        end
        if (s_valid && rdy) hs_cnt++;
        if (redir)                model_next = rpc & 32'hFFFF_FFFC;
        else if (s_valid && rdy)  model_next = model_next + 32'd4;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        tick(1'b0, 1'b0, 32'h0);
        while (!s_valid && k < budget) begin
            tick(1'b0, 1'b0, 32'h0);
            k++;
        end
        chk(tag, 32'(s_valid), 32'h1);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int k = 0;
        tick(1'b0, 1'b0, 32'h0);
        while (!s_req && k < budget) begin
            if (s_valid && s_pc != model_next) saw_flushed = 1'b1;
            tick(1'b0, 1'b0, 32'h0);
            k++;
        end
        chk(tag, 32'(s_req), 32'h1);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        pend        = 1'b0;
        outstanding = 1'b0;
        model_next  = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        lat = 1; model_next = 32'h0; outstanding = 1'b0; pend = 1'b0; hs_cnt = 0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_opcode", 32'(opcode), 32'h13);
        chk("rst_instr_pc", instr_pc, 32'h0);
        w_rst_n = 1'b1;
        rst_n   = 1'b1;

        // Straight-line fetch, ready always high
        first_done = 1'b0;
        n = 0;
        while (req_log.size() < 3 && n < 40) begin
            tick(1'b1, 1'b0, 32'h0);
            if (s_valid && !first_done) begin
                first_done = 1'b1;
                chk("first_pc", s_pc, 32'h0);
                chk("first_opcode", 32'(s_op), 32'h13);
                chk("first_instr", s_instr, 32'h0050_0093);
            end
            n++;
        end
        chk("first_seen", 32'(first_done), 32'h1);
        chk("seq_len", 32'(req_log.size()), 32'd3);
        if (req_log.size() >= 3) begin
            chk("seq_addr0", req_log[0], 32'h0);
            chk("seq_addr1", req_log[1], 32'h4);
            chk("seq_addr2", req_log[2], 32'h8);
        end

        // Backpressure on the word at 0x4
        do_reset();
        wait_valid(20, "wait_valid_0");
        tick(1'b1, 1'b0, 32'h0);
        wait_valid(20, "wait_valid_4");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            chk("hold_valid", 32'(s_valid), 32'h1);
            chk("hold_instr", s_instr, 32'h00C5_8533);
            chk("hold_pc", s_pc, 32'h4);
            chk("hold_no_req", 32'(s_req), 32'h0);
        end
        tick(1'b1, 1'b0, 32'h0);

        // Redirect while waiting on 0x8 with 3-cycle memory
        lat = 3;
        saw_flushed = 1'b0;
        wait_req(10, "req_8_issued");
        chk("req_8_addr", s_addr, 32'h8);
        tick(1'b0, 1'b1, 32'h100);
        wait_req(20, "req_100_issued");
        chk("req_after_wait_redirect", s_addr, 32'h100);
        chk("no_valid_for_8", 32'(saw_flushed), 32'h0);
        wait_valid(20, "wait_valid_100");
        chk("valid_100_pc", s_pc, 32'h100);

        // Redirect coincident with rvalid, unaligned target
        tick(1'b1, 1'b0, 32'h0);
        lat = 1;
        wait_req(10, "req_104_issued");
        chk("req_104_addr", s_addr, 32'h104);
        tick(1'b0, 1'b1, 32'h203);
        chk("coincident_rvalid", 32'(s_rv), 32'h1);
        wait_req(10, "req_200_issued");
        chk("req_after_coincident", s_addr, 32'h200);
        chk("no_valid_for_104", 32'(saw_flushed), 32'h0);
        wait_valid(20, "wait_valid_200");
        chk("valid_200_pc", s_pc, 32'h200);

        // Random latency, backpressure and redirects
        hs0 = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) lat = int'($urandom_range(1, 4));
            rdy_r   = ($urandom_range(0, 9) < 6);
            redir_r = ($urandom_range(0, 15) == 0);
            rpc_r   = $urandom;
            tick(rdy_r, redir_r, rpc_r);
        end
        chk("random_progress", 32'((hs_cnt - hs0) >= 100), 32'h1);

        // Asynchronous reset while holding an instruction
        wait_valid(40, "hold_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(instr_valid), 32'h0);
        chk("async_rst_opcode", 32'(opcode), 32'h13);
        chk("async_rst_instr", instr, 32'h0000_0013);
        chk("async_rst_req", 32'(imem_req), 32'h0);
        pend = 1'b0; outstanding = 1'b0; model_next = 32'h0; imem_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // A stale response arriving right after reset must be ignored
        lat = 1;
        pend = 1'b1; pend_cnt = 1; pend_addr = 32'hDEAD_BEE0;
        wait_valid(20, "valid_after_reset");
        chk("post_reset_pc", s_pc, 32'h0);
        chk("post_reset_instr", s_instr, 32'h0050_0093);

        // PC wrap
        chk("wrap_len", 32'(w_log.size() >= 2), 32'h1);
        if (w_log.size() >= 2) begin
            chk("wrap_addr0", w_log[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", w_log[1], 32'h0000_0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have the port imem_req, output, 1 bit, a one-cycle read strobe to instruction memory.
REQ-005 The block SHALL have the port imem_addr, output, 32 bits, the word-aligned read address, valid while imem_req=1.
REQ-006 The block SHALL have the port imem_rvalid, input, 1 bit; it pulses once per request, at least 1 cycle after imem_req.
REQ-007 The block SHALL have the port imem_rdata, input, 32 bits, the instruction word, valid while imem_rvalid=1.
REQ-008 The block SHALL have the port redirect, input, 1 bit, a branch/jump taken pulse from execute.
REQ-009 The block SHALL have the port redirect_pc, input, 32 bits, the target address; bits [1:0] are ignored and forced to 0.
REQ-010 The block SHALL have the port instr_valid, output, 1 bit, meaning an instruction is presented to decode/control.
REQ-011 The block SHALL have the port instr_ready, input, 1 bit, the decode accept signal.
REQ-012 The block SHALL have the port instr, output, 32 bits, the registered instruction word.
REQ-013 The block SHALL have the port opcode, output, 7 bits, equal to instr[6:0] and feeding the control unit opcode input.
REQ-014 The block SHALL have the port instr_pc, output, 32 bits, the address instr was fetched from.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, FETCH, WAIT, DRAIN and HOLD.
REQ-016 IDLE SHALL go to FETCH unconditionally one cycle after reset release, with pc=RESET_PC.
REQ-017 FETCH SHALL assert imem_req=1 with imem_addr=pc for exactly one cycle, then go to WAIT.
REQ-018 WAIT on imem_rvalid SHALL capture instr<=imem_rdata and instr_pc<=pc, set instr_valid the next cycle, and go to HOLD.
REQ-019 Latency SHALL be exactly 1 cycle from the imem_rvalid edge to instr_valid high.
REQ-020 HOLD SHALL keep instr, instr_pc and instr_valid stable until instr_valid&instr_ready at a clock edge; then it SHALL clear instr_valid, set pc<=pc+4 and go to FETCH.
REQ-021 Only one memory request SHALL be outstanding at any time; imem_req SHALL never assert outside FETCH.
REQ-022 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-023 A redirect in FETCH SHALL suppress imem_req that cycle, load pc<=redirect_pc and stay in FETCH.
REQ-024 A redirect in WAIT without imem_rvalid SHALL load pc and go to DRAIN.
REQ-025 DRAIN SHALL discard the next imem_rvalid and then go to FETCH.
REQ-026 A redirect in WAIT coincident with imem_rvalid SHALL discard that data, load pc and go to FETCH.
REQ-027 A redirect in DRAIN SHALL only update pc, so the latest redirect wins.
REQ-028 A redirect in HOLD SHALL clear instr_valid, load pc and go to FETCH.
REQ-029 If instr_ready is also high on a HOLD redirect, the transfer SHALL count as consumed and pc SHALL still take redirect_pc, not pc+4.
REQ-030 The only path into HOLD SHALL be through WAIT with imem_rvalid and no redirect, so instr_valid never presents a flushed word.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instr_valid=0, instr=32'h0000_0013 (NOP), opcode=7'b0010011 and instr_pc=0.
REQ-032 Reset mid-WAIT SHALL drop the in-flight response.
REQ-033 The first imem_rvalid after reset release SHALL be accepted only if it answers a post-reset request.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the NOP constant 32'h0000_0013 and the opcode constants OP_R=0110011, OP_S=0100011, OP_I=0010011, OP_L=0000011, OP_B=1100011, OP_JAL=1101111 and OP_JALR=1100111; these are shared with the control unit.
REQ-035 The block SHALL contain a single sub-module, pc_reg, holding the PC register with its +4/redirect/reset mux.

Verification
REQ-036 Reset: after release, memory returns 0x00500093 at 0x0 with 1-cycle latency and ready=1 -> imem_addr sequence 0x0, 0x4, 0x8, with instr_pc=0x0 and opcode=0010011 on the first valid.
REQ-037 Backpressure: ready=0 for 5 cycles with instr=0x00C58533 -> instr_valid, instr and instr_pc stay constant and no imem_req is issued until ready=1.
REQ-038 Redirect in WAIT: redirect to 0x100 while waiting on 0x8, memory latency 3 -> the 0x8 data is discarded, the next imem_addr is 0x100, and no instr_valid for 0x8.
REQ-039 Redirect plus rvalid in the same cycle, target 0x203 -> the data is dropped and the next imem_addr is 0x200.
REQ-040 Wrap: RESET_PC=0xFFFFFFFC -> the second request address is 0x00000000.
REQ-041 Async reset while in HOLD, between clock edges -> instr_valid falls without a clock edge, and opcode returns to 0010011.
